// File: rtl/sg_pkg.sv
`default_nettype none
// ============================================================================
//  sg_pkg
//  Shared types and default sizes for the Savitzky-Golay smoothing path.
//  Revision: 1.0
// ============================================================================
package sg_pkg;

  // Defaults shared with the filter core
  localparam int c_DEF_WINDOW_SIZE = 7;
  localparam int c_DEF_DATA_W      = 8;
  localparam int c_DEF_ADDR_W      = 10;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    ISSUE    = 3'd2,
    WAIT     = 3'd3,
    SHIFT    = 3'd4,
    PAD_HEAD = 3'd5,
    PAD_TAIL = 3'd6,
    FINISH   = 3'd7
  } sg_state_e;

endpackage : sg_pkg
`default_nettype wire

// File: rtl/sg_window_shreg.sv
`default_nettype none
// ============================================================================
//  sg_window_shreg
//  W-deep sample shift register. New samples enter at slot W-1, the oldest
//  sample sits in slot 0, which is mapped to the LSBs of o_win.
//  Revision: 1.0
// ============================================================================
module sg_window_shreg
  import sg_pkg::*;
#(
  parameter int WINDOW_SIZE = c_DEF_WINDOW_SIZE,
  parameter int DATA_W      = c_DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_shift_en,
  input  logic [DATA_W-1:0]             i_data,
  output logic [WINDOW_SIZE*DATA_W-1:0] o_win
);

  logic [DATA_W-1:0] r_slot [WINDOW_SIZE];

  // Shift one slot toward slot 0 and load the new sample at the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_shift_en) begin
      for (int i = 0; i < WINDOW_SIZE-1; i++) begin
        r_slot[i] <= r_slot[i+1];
      end
      r_slot[WINDOW_SIZE-1] <= i_data;
    end
  end

  generate
    for (genvar g = 0; g < WINDOW_SIZE; g++) begin : g_flat
      assign o_win[g*DATA_W +: DATA_W] = r_slot[g];
    end
  endgenerate

endmodule : sg_window_shreg
`default_nettype wire

// File: rtl/sg_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  sg_frame_ctrl
//  Frame sequencer: primes a sliding window from the sample RAM, runs one
//  filter-core job per centre position, writes results, then replicates the
//  first/last result into the half-window edges of the output RAM.
//  Revision: 1.0
//
//  Frame time (start cycle and done cycle both counted), 1-cycle core:
//    1 (start) + (W+1) prime + n*(lat+1) issue/wait + (n-1) shift
//    + 2H pad + 1 finish, with n = len-W+1 windows.
//  W=7, len=10, lat=1: 1 + 8 + 4*2 + 3 + 6 + 1 = 27.
//  W=7, len=7,  lat=1: 1 + 8 + 1*2 + 0 + 6 + 1 = 18.
// ============================================================================
module sg_frame_ctrl
  import sg_pkg::*;
#(
  parameter int WINDOW_SIZE = c_DEF_WINDOW_SIZE,
  parameter int DATA_W      = c_DEF_DATA_W,
  parameter int ADDR_W      = c_DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [ADDR_W:0]               i_frame_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_rd_en,
  output logic [ADDR_W-1:0]             o_rd_addr,
  input  logic [DATA_W-1:0]             i_rd_data,
  output logic [WINDOW_SIZE*DATA_W-1:0] o_win,
  output logic                          o_core_start,
  input  logic                          i_core_done,
  input  logic [DATA_W-1:0]             i_core_result,
  output logic                          o_wr_en,
  output logic [ADDR_W-1:0]             o_wr_addr,
  output logic [DATA_W-1:0]             o_wr_data
);

  localparam int c_H = WINDOW_SIZE / 2;

  // Counter-width constants (ADDR_W+1 bits so len = 2^ADDR_W is representable)
  localparam logic [ADDR_W:0]   c_W_LEN   = (ADDR_W+1)'(WINDOW_SIZE);
  localparam logic [ADDR_W:0]   c_H_LEN   = (ADDR_W+1)'(c_H);
  localparam logic [ADDR_W:0]   c_H1_LEN  = (ADDR_W+1)'(c_H + 1);
  localparam logic [ADDR_W:0]   c_HM1_LEN = (ADDR_W+1)'(c_H - 1);
  localparam logic [ADDR_W:0]   c_ONE_LEN = (ADDR_W+1)'(1);
  // Address-width constants; address sums always land below len, so modulo
  // 2^ADDR_W arithmetic yields the exact address.
  localparam logic [ADDR_W-1:0] c_H_A     = ADDR_W'(c_H);
  localparam logic [ADDR_W-1:0] c_H1_A    = ADDR_W'(c_H + 1);

  sg_state_e         r_state;
  sg_state_e         w_state_nxt;

  logic [ADDR_W:0]   r_len;     // latched frame length
  logic [ADDR_W:0]   r_cnt;     // prime read index / pad index
  logic [ADDR_W:0]   r_ctr;     // current centre index c
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic              r_err;
  logic              r_rd_vld;  // rd_data carries a sample this cycle

  logic              w_len_short;
  logic              w_prime_end;
  logic              w_pad_end;
  logic              w_is_head;
  logic              w_is_last;
  logic [ADDR_W-1:0] w_rd_next;
  logic [ADDR_W-1:0] w_tail_addr;

  assign w_len_short = (i_frame_len < c_W_LEN);
  // All W reads issued; the last sample is on rd_data this cycle
  assign w_prime_end = (r_cnt == c_W_LEN);
  assign w_pad_end   = (r_cnt == c_HM1_LEN);
  assign w_is_head   = (r_ctr == c_H_LEN);
  assign w_is_last   = (r_ctr == (r_len - c_H1_LEN));
  assign w_rd_next   = r_ctr[ADDR_W-1:0] + c_H1_A;
  assign w_tail_addr = r_len[ADDR_W-1:0] - c_H_A + r_cnt[ADDR_W-1:0];

  assign o_err = r_err;

  sg_window_shreg #(
    .WINDOW_SIZE (WINDOW_SIZE),
    .DATA_W      (DATA_W)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (r_rd_vld),
    .i_data     (i_rd_data),
    .o_win      (o_win)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read-valid tracker: sample RAM has one cycle of read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= o_rd_en;
    end
  end

  // Next-state and strobes; the result write and the next read share a cycle
  always_comb begin
    w_state_nxt  = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_rd_en      = 1'b0;
    o_rd_addr    = '0;
    o_core_start = 1'b0;
    o_wr_en      = 1'b0;
    o_wr_addr    = '0;
    o_wr_data    = '0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = w_len_short ? FINISH : PRIME;
        end
      end
      PRIME: begin
        o_busy = 1'b1;
        if (w_prime_end) begin
          w_state_nxt = ISSUE;
        end else begin
          o_rd_en   = 1'b1;
          o_rd_addr = r_cnt[ADDR_W-1:0];
        end
      end
      ISSUE: begin
        o_busy       = 1'b1;
        o_core_start = 1'b1;
        w_state_nxt  = WAIT;
      end
      WAIT: begin
        o_busy = 1'b1;
        if (i_core_done) begin
          o_wr_en   = 1'b1;
          o_wr_addr = r_ctr[ADDR_W-1:0];
          o_wr_data = i_core_result;
          if (w_is_last) begin
            w_state_nxt = PAD_HEAD;
          end else begin
            o_rd_en     = 1'b1;
            o_rd_addr   = w_rd_next;
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        o_busy      = 1'b1;
        w_state_nxt = ISSUE;
      end
      PAD_HEAD: begin
        o_busy    = 1'b1;
        o_wr_en   = 1'b1;
        o_wr_addr = r_cnt[ADDR_W-1:0];
        o_wr_data = r_head;
        if (w_pad_end) begin
          w_state_nxt = PAD_TAIL;
        end
      end
      PAD_TAIL: begin
        o_busy    = 1'b1;
        o_wr_en   = 1'b1;
        o_wr_addr = w_tail_addr;
        o_wr_data = r_tail;
        if (w_pad_end) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Frame bookkeeping: length, error flag, counters and edge values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_ctr  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_len <= i_frame_len;
            r_err <= w_len_short;
            r_cnt <= '0;
            r_ctr <= c_H_LEN;
          end
        end
        PRIME: begin
          r_cnt <= w_prime_end ? '0 : (r_cnt + c_ONE_LEN);
        end
        WAIT: begin
          if (i_core_done) begin
            if (w_is_head) begin
              r_head <= i_core_result;
            end
            if (w_is_last) begin
              r_tail <= i_core_result;
              r_cnt  <= '0;
            end else begin
              r_ctr <= r_ctr + c_ONE_LEN;
            end
          end
        end
        PAD_HEAD: begin
          r_cnt <= w_pad_end ? '0 : (r_cnt + c_ONE_LEN);
        end
        PAD_TAIL: begin
          r_cnt <= r_cnt + c_ONE_LEN;
        end
        default: begin
        end
      endcase
    end
  end

endmodule : sg_frame_ctrl
`default_nettype wire

// File: tb/tb_sg_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_sg_frame_ctrl
//  Directed bench: ramp sample RAM, slot-3 core model with programmable
//  latency, write log compared against hand-derived expectations.
//  Revision: 1.0
// ============================================================================
module tb_sg_frame_ctrl;
  import sg_pkg::*;

  localparam int W  = 7;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int H  = W / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     frame_len;
  logic            busy, done, err, rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data = '0;
  logic [W*DW-1:0] win;
  logic            core_start, core_done;
  logic [DW-1:0]   core_result;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  int            core_lat = 1;
  int            ram_base = 0;
  logic          inj_done = 1'b0;
  int            core_cnt;
  logic          core_done_m;
  logic [DW-1:0] core_res;

  int   n_total = 0;
  int   n_bad   = 0;
  int   q_addr[$];
  int   q_data[$];
  int   rd_cnt, cs_cnt, done_cnt, done_err, t_frame;
  logic got_done;

  always #5 clk = ~clk;

  sg_frame_ctrl #(
    .WINDOW_SIZE (W),
    .DATA_W      (DW),
    .ADDR_W      (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_frame_len   (frame_len),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_rd_en       (rd_en),
    .o_rd_addr     (rd_addr),
    .i_rd_data     (rd_data),
    .o_win         (win),
    .o_core_start  (core_start),
    .i_core_done   (core_done),
    .i_core_result (core_result),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data)
  );

  // Synchronous sample RAM: word at address a holds ram_base + a
  always @(posedge clk) begin
    if (rd_en) rd_data <= DW'(ram_base + int'(rd_addr));
  end

  // Core model: returns window slot 3, core_lat cycles after core_start
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt    <= 0;
      core_done_m <= 1'b0;
      core_res    <= '0;
    end else begin
      core_done_m <= 1'b0;
      if (core_start) begin
        core_res <= win[3*DW +: DW];
        if (core_lat == 1) core_done_m <= 1'b1;
        else               core_cnt    <= core_lat - 1;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) core_done_m <= 1'b1;
      end
    end
  end

  assign core_done   = core_done_m | inj_done;
  assign core_result = core_res;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One frame: pulse start, log strobes at negedges until a few cycles past done
  task automatic run_frame(input int len, input int lat, input int base,
                           input int inj_s, input int inj_d);
    int k;
    int k_done;
    core_lat = lat;
    ram_base = base;
    q_addr.delete();
    q_data.delete();
    rd_cnt = 0; cs_cnt = 0; done_cnt = 0; done_err = 0; t_frame = 0;
    got_done = 1'b0;
    k_done = 0;
    @(negedge clk);
    frame_len = (AW+1)'(len);
    start = 1'b1;
    k = 0;
    while (k < 600 && !(got_done && k >= k_done + 6)) begin
      @(negedge clk);
      k++;
      if (wr_en) begin
        q_addr.push_back(int'(wr_addr));
        q_data.push_back(int'(wr_data));
      end
      if (rd_en) rd_cnt++;
      if (core_start) cs_cnt++;
      if (done) begin
        done_cnt++;
        done_err = int'(err);
        if (!got_done) begin
          got_done = 1'b1;
          k_done   = k;
          t_frame  = k + 1;
        end
      end
      start = (k == inj_s);
      if (k == inj_s) frame_len = (AW+1)'(5);
      inj_done = (k == inj_d);
    end
    start = 1'b0;
    inj_done = 1'b0;
  endtask

  task automatic check_wr(input string nm, input int idx, input int ea, input int ed);
    check_eq({nm, "_wr_addr"}, 64'((idx < q_addr.size()) ? q_addr[idx] : -1), 64'(ea));
    check_eq({nm, "_wr_data"}, 64'((idx < q_data.size()) ? q_data[idx] : -1), 64'(ed));
  endtask

  // Expected order: centres ascending, head pad, tail pad
  task automatic check_frame(input string nm, input int len, input int base, input int t_exp);
    int idx;
    check_eq({nm, "_done_seen"}, 64'(got_done), 64'(1));
    check_eq({nm, "_done_cnt"},  64'(done_cnt), 64'(1));
    check_eq({nm, "_err"},       64'(done_err), 64'(0));
    check_eq({nm, "_time"},      64'(t_frame),  64'(t_exp));
    check_eq({nm, "_n_core"},    64'(cs_cnt),   64'(len - W + 1));
    check_eq({nm, "_n_rd"},      64'(rd_cnt),   64'(len));
    check_eq({nm, "_n_wr"},      64'(q_addr.size()), 64'(len));
    idx = 0;
    for (int c = H; c <= len - H - 1; c++) begin
      check_wr(nm, idx, c, (base + c) % 256);
      idx++;
    end
    for (int a = 0; a < H; a++) begin
      check_wr(nm, idx, a, (base + H) % 256);
      idx++;
    end
    for (int a = len - H; a < len; a++) begin
      check_wr(nm, idx, a, (base + len - H - 1) % 256);
      idx++;
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    frame_len = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl",  64'({busy, done, err, rd_en, core_start, wr_en}), 64'(0));
    check_eq("rst_addr",  64'({rd_addr, wr_addr, wr_data}), 64'(0));
    check_eq("rst_win",   64'(win), 64'(0));
    check_eq("rst_state", 64'(dut.r_state), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Ramp, len=10, 1-cycle core
    run_frame(10, 1, 0, -1, -1);
    check_frame("ramp", 10, 0, 27);

    // len == W: single core job fills every address
    run_frame(7, 1, 40, -1, -1);
    check_frame("lenw", 7, 40, 18);

    // Short frame: immediate error, no traffic
    run_frame(5, 1, 0, -1, -1);
    check_eq("short_done_cnt", 64'(done_cnt), 64'(1));
    check_eq("short_err",      64'(done_err), 64'(1));
    check_eq("short_time",     64'(t_frame),  64'(2));
    check_eq("short_traffic",  64'(rd_cnt + cs_cnt + q_addr.size()), 64'(0));
    check_eq("short_err_hold", 64'({busy, err}), 64'(1));

    // 5-cycle core with a stray start (and len=5) during WAIT
    run_frame(10, 5, 0, 12, -1);
    check_frame("lat5", 10, 0, 43);

    // core_done pulse during PRIME must be ignored
    run_frame(10, 1, 100, -1, 3);
    check_frame("injd", 10, 100, 27);

    // Reset while waiting on the core
    core_lat = 5;
    ram_base = 0;
    @(negedge clk);
    frame_len = (AW+1)'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!core_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("rstw_issue", 64'(core_start), 64'(1));
    @(negedge clk);
    check_eq("rstw_in_wait", 64'(dut.r_state), 64'(WAIT));
    rst = 1'b1;
    #1;
    check_eq("rstw_ctrl",  64'({busy, done, err, rd_en, core_start, wr_en}), 64'(0));
    check_eq("rstw_addr",  64'({rd_addr, wr_addr, wr_data}), 64'(0));
    check_eq("rstw_win",   64'(win), 64'(0));
    check_eq("rstw_state", 64'(dut.r_state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(10, 1, 7, -1, -1);
    check_frame("after_rst", 10, 7, 27);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_sg_frame_ctrl
`default_nettype wire
